// File: rtl/pool1_relu_if.sv
// Bundle between pool1_relu and its neighbours: run request, feature maps,
// completion flag and an FSM state tap for debug/checkers.
//
// Handshake: ena is a level-sensitive run request. Raising it from IDLE
// starts a computation. Holding it high keeps the run going and then holds
// the finished result. Dropping it aborts a run, or releases a finished
// result. done is a level that stays high while tensor_out holds a complete
// result and ena is still high. tensor_in must stay stable from the start
// edge until done.
interface pool1_relu_if #(
    parameter int IN_DIM = 24,
    parameter int DATA_W = 8
);
    localparam int OUT_DIM = IN_DIM / 2;

    logic                                ena;
    logic [IN_DIM*IN_DIM*DATA_W-1:0]     tensor_in;
    logic [OUT_DIM*OUT_DIM*DATA_W-1:0]   tensor_out;
    logic                                done;
    logic [1:0]                          fsm_state;

    modport master (
        output ena,
        output tensor_in,
        input  tensor_out,
        input  done,
        input  fsm_state
    );

    modport slave (
        input  ena,
        input  tensor_in,
        output tensor_out,
        output done,
        output fsm_state
    );
endinterface

// File: rtl/pool1_relu.sv
// 2x2 stride-2 signed max pooling followed by ReLU over an IN_DIM x IN_DIM
// Q1.7 map. One window is evaluated per clock, selected by row/column
// counters, so only a single 4-input max and a ReLU mux are needed.
module pool1_relu #(
    parameter int IN_DIM = 24,
    parameter int DATA_W = 8
) (
    input logic          clk,
    input logic          iRst_n,
    pool1_relu_if.slave  bus
);
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CNT_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] row_q, col_q;
    logic             wr_en, clr_idx, last_win, last_col;

    logic [31:0] base_top, base_bot, slot_base;

    logic signed [DATA_W-1:0] px0, px1, px2, px3;
    logic signed [DATA_W-1:0] max01, max23, max_all;
    logic        [DATA_W-1:0] relu_val;

    logic [OUT_DIM*OUT_DIM*DATA_W-1:0] out_q;
    logic                              done_q;

    assign last_col = (col_q == CNT_W'(OUT_DIM - 1));
    assign last_win = last_col && (row_q == CNT_W'(OUT_DIM - 1));

    // Fetch the four inputs of the current window and reduce them to one value.
    always_comb begin
        base_top  = 32'(((2 * int'(row_q)) * IN_DIM + 2 * int'(col_q)) * DATA_W);
        base_bot  = base_top + 32'(IN_DIM * DATA_W);
        slot_base = 32'((int'(row_q) * OUT_DIM + int'(col_q)) * DATA_W);
        px0       = bus.tensor_in[base_top          +: DATA_W];
        px1       = bus.tensor_in[base_top + DATA_W +: DATA_W];
        px2       = bus.tensor_in[base_bot          +: DATA_W];
        px3       = bus.tensor_in[base_bot + DATA_W +: DATA_W];
        max01     = (px0 > px1) ? px0 : px1;
        max23     = (px2 > px3) ? px2 : px3;
        max_all   = (max01 > max23) ? max01 : max23;
        relu_val  = max_all[DATA_W-1] ? '0 : max_all;
    end

    // Next-state and control decode.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        clr_idx = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ena) begin
                    state_d = RUN;
                    clr_idx = 1'b1;
                end
            end
            RUN: begin
                if (!bus.ena) begin
                    // Abort: keep what was written, restart from window 0 next time.
                    state_d = IDLE;
                    clr_idx = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    if (last_win) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.ena) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                clr_idx = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Row-major window counter; column runs fastest and wraps after the last window.
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clr_idx) begin
            row_q <= '0;
            col_q <= '0;
        end else if (wr_en) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_win ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Result map: one slot written per RUN cycle, all others held.
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            out_q <= '0;
        end else if (wr_en) begin
            out_q[slot_base +: DATA_W] <= relu_val;
        end
    end

    // done tracks residency in DONE, registered together with the state.
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_d == DONE);
        end
    end

    assign bus.tensor_out = out_q;
    assign bus.done       = done_q;
    assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_pool1_relu.sv
// Bench for pool1_relu: table of window/fill vectors, ramp mapping, random
// maps against a loop-based pooling model, abort/restart and reset cases.
module tb_pool1_relu;
    localparam int IN_DIM   = 24;
    localparam int DATA_W   = 8;
    localparam int OUT_DIM  = IN_DIM / 2;
    localparam int N_WIN    = OUT_DIM * OUT_DIM;
    localparam int IN_BITS  = IN_DIM * IN_DIM * DATA_W;
    localparam int OUT_BITS = OUT_DIM * OUT_DIM * DATA_W;

    logic clk;
    logic rst_n;

    pool1_relu_if #(.IN_DIM(IN_DIM), .DATA_W(DATA_W)) bus ();

    pool1_relu #(.IN_DIM(IN_DIM), .DATA_W(DATA_W)) dut (
        .clk    (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    // Clock: 10 time units, rising edges at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [7:0] fill;
        logic [7:0] w0, w1, w2, w3;
        int         wi, wj;
        logic [7:0] exp_win;
        logic [7:0] exp_fill;
    } vec_t;

    vec_t vecs[6];

    // Reference model: plain loops over windows with integer arithmetic.
    function automatic logic [OUT_BITS-1:0] ref_pool(input logic [IN_BITS-1:0] t);
        logic [OUT_BITS-1:0] r;
        int m;
        int v;
        r = '0;
        for (int i = 0; i < OUT_DIM; i++) begin
            for (int j = 0; j < OUT_DIM; j++) begin
                m = -1000;
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        v = int'($signed(t[((2*i+dr)*IN_DIM + 2*j+dc)*DATA_W +: DATA_W]));
                        if (v > m) m = v;
                    end
                end
                if (m < 0) m = 0;
                r[(i*OUT_DIM+j)*DATA_W +: DATA_W] = 8'(m);
            end
        end
        return r;
    endfunction

    function automatic logic [IN_BITS-1:0] random_map();
        logic [IN_BITS-1:0] t;
        for (int e = 0; e < IN_DIM*IN_DIM; e++) begin
            t[e*DATA_W +: DATA_W] = 8'($urandom_range(0, 255));
        end
        return t;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic check_map(input string name, input logic [OUT_BITS-1:0] got,
                             input logic [OUT_BITS-1:0] exp);
        int first_bad;
        first_bad = -1;
        for (int s = 0; s < N_WIN; s++) begin
            if (first_bad < 0 && got[s*DATA_W +: DATA_W] !== exp[s*DATA_W +: DATA_W]) begin
                first_bad = s;
            end
        end
        n_vec++;
        if (first_bad >= 0) begin
            n_bad++;
            $display("FAIL %s: slot %0d got 0x%0h, expected 0x%0h", name, first_bad,
                     got[first_bad*DATA_W +: DATA_W], exp[first_bad*DATA_W +: DATA_W]);
        end
    endtask

    // Full run from IDLE: latency, result, hold while ena=1, release on ena=0.
    task automatic run_and_check(input string name, input logic [IN_BITS-1:0] tin,
                                 input logic [OUT_BITS-1:0] exp);
        int  k;
        logic seen;
        @(negedge clk);
        bus.tensor_in = tin;
        bus.ena       = 1'b1;
        @(posedge clk);              // E0
        k    = 0;
        seen = 1'b0;
        while (!seen && k < N_WIN + 20) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: done not seen in %0d edges, expected at %0d", name, k, N_WIN);
        end else begin
            check_val({name, " latency"}, k, N_WIN);
        end
        check_map({name, " result"}, bus.tensor_out, exp);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_val({name, " done hold"}, 32'(bus.done), 32'd1);
        check_map({name, " result hold"}, bus.tensor_out, exp);
        @(negedge clk);
        bus.ena = 1'b0;
        @(posedge clk);
        #1;
        check_val({name, " done release"}, 32'(bus.done), 32'd0);
        check_map({name, " result after release"}, bus.tensor_out, exp);
    endtask

    logic [IN_BITS-1:0]  tin;
    logic [IN_BITS-1:0]  ramp;
    logic [OUT_BITS-1:0] exp_map;
    logic [OUT_BITS-1:0] prev_map;
    logic [OUT_BITS-1:0] merged;
    int                  k;
    logic                seen;

    initial begin
        n_vec = 0;
        n_bad = 0;

        vecs[0] = '{fill: 8'h22, w0: 8'h22, w1: 8'h22, w2: 8'h22, w3: 8'h22, wi: 0,  wj: 0,  exp_win: 8'h22, exp_fill: 8'h22};
        vecs[1] = '{fill: 8'hC0, w0: 8'hC0, w1: 8'hC0, w2: 8'hC0, w3: 8'hC0, wi: 0,  wj: 0,  exp_win: 8'h00, exp_fill: 8'h00};
        vecs[2] = '{fill: 8'h80, w0: 8'h80, w1: 8'h7F, w2: 8'h01, w3: 8'hFF, wi: 5,  wj: 6,  exp_win: 8'h7F, exp_fill: 8'h00};
        vecs[3] = '{fill: 8'h80, w0: 8'hFF, w1: 8'hFE, w2: 8'h80, w3: 8'h81, wi: 11, wj: 0,  exp_win: 8'h00, exp_fill: 8'h00};
        vecs[4] = '{fill: 8'h80, w0: 8'h80, w1: 8'h80, w2: 8'h80, w3: 8'h02, wi: 0,  wj: 11, exp_win: 8'h02, exp_fill: 8'h00};
        vecs[5] = '{fill: 8'h7F, w0: 8'h80, w1: 8'h81, w2: 8'h82, w3: 8'h83, wi: 11, wj: 11, exp_win: 8'h00, exp_fill: 8'h7F};

        // Reset state, without any clock edge needed.
        rst_n         = 1'b0;
        bus.ena       = 1'b0;
        bus.tensor_in = '0;
        #2;
        check_map("reset map", bus.tensor_out, '0);
        check_val("reset done", 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_map("idle map after release", bus.tensor_out, '0);
        check_val("idle done after release", 32'(bus.done), 32'd0);

        // Table-driven fill / single-window vectors.
        for (int v = 0; v < 6; v++) begin
            for (int e = 0; e < IN_DIM*IN_DIM; e++) tin[e*DATA_W +: DATA_W] = vecs[v].fill;
            tin[((2*vecs[v].wi)  *IN_DIM + 2*vecs[v].wj  )*DATA_W +: DATA_W] = vecs[v].w0;
            tin[((2*vecs[v].wi)  *IN_DIM + 2*vecs[v].wj+1)*DATA_W +: DATA_W] = vecs[v].w1;
            tin[((2*vecs[v].wi+1)*IN_DIM + 2*vecs[v].wj  )*DATA_W +: DATA_W] = vecs[v].w2;
            tin[((2*vecs[v].wi+1)*IN_DIM + 2*vecs[v].wj+1)*DATA_W +: DATA_W] = vecs[v].w3;
            for (int s = 0; s < N_WIN; s++) exp_map[s*DATA_W +: DATA_W] = vecs[v].exp_fill;
            exp_map[(vecs[v].wi*OUT_DIM + vecs[v].wj)*DATA_W +: DATA_W] = vecs[v].exp_win;
            check_map($sformatf("vec%0d model agrees", v), ref_pool(tin), exp_map);
            run_and_check($sformatf("vec%0d", v), tin, exp_map);
        end

        // Mapping ramp: in(r,c) = 4r + c.
        for (int r = 0; r < IN_DIM; r++) begin
            for (int c = 0; c < IN_DIM; c++) ramp[(r*IN_DIM+c)*DATA_W +: DATA_W] = 8'(4*r + c);
        end
        run_and_check("ramp", ramp, ref_pool(ramp));
        check_val("ramp out(0,0)",   32'(bus.tensor_out[(0*OUT_DIM+0)*DATA_W +: DATA_W]),   32'd5);
        check_val("ramp out(11,11)", 32'(bus.tensor_out[(11*OUT_DIM+11)*DATA_W +: DATA_W]), 32'd115);
        check_val("ramp out(3,7)",   32'(bus.tensor_out[(3*OUT_DIM+7)*DATA_W +: DATA_W]),   32'd43);

        // Random maps against the model.
        for (int n = 0; n < 3; n++) begin
            tin = random_map();
            run_and_check($sformatf("random%0d", n), tin, ref_pool(tin));
        end
        prev_map = ref_pool(tin);

        // Abort after window 50 has been written (edge E51), then restart.
        tin    = random_map();
        merged = prev_map;
        exp_map = ref_pool(tin);
        for (int s = 0; s <= 50; s++) merged[s*DATA_W +: DATA_W] = exp_map[s*DATA_W +: DATA_W];
        @(negedge clk);
        bus.tensor_in = tin;
        bus.ena       = 1'b1;
        @(posedge clk);              // E0
        repeat (51) @(posedge clk);  // E1..E51
        #1;
        check_val("abort done before drop", 32'(bus.done), 32'd0);
        @(negedge clk);
        bus.ena = 1'b0;
        @(posedge clk);
        #1;
        check_map("abort partial result", bus.tensor_out, merged);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_val("abort done stays low", 32'(bus.done), 32'd0);
        check_map("abort result held", bus.tensor_out, merged);
        run_and_check("restart after abort", tin, exp_map);

        // Reset while in DONE clears immediately.
        tin = random_map();
        @(negedge clk);
        bus.tensor_in = tin;
        bus.ena       = 1'b1;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < N_WIN + 20) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check_val("pre-reset done reached", 32'(seen), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async reset done", 32'(bus.done), 32'd0);
        check_map("async reset map", bus.tensor_out, '0);
        bus.ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset pulse mid-run, then a clean run from window 0.
        @(negedge clk);
        bus.tensor_in = ramp;
        bus.ena       = 1'b1;
        repeat (31) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_map("mid-run reset map", bus.tensor_out, '0);
        check_val("mid-run reset done", 32'(bus.done), 32'd0);
        bus.ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_map("post-reset idle map", bus.tensor_out, '0);
        run_and_check("run after reset", ramp, ref_pool(ramp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish, limit 200000");
        $fatal(1, "timeout");
    end
endmodule
